// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register driven by the hazard unit's 2-bit write code,
// with saturating stall/flush counters and a sticky watchdog for long keep streaks.
module pipe_stage_reg #(
    parameter int DW         = 64,
    parameter int CNT_W      = 32,
    parameter int HANG_LIMIT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       wr_ctrl,
    input  logic             valid_i,
    input  logic [DW-1:0]    data_i,
    input  logic [63:0]      pc_i,
    input  logic             perf_clr,
    output logic             valid_o,
    output logic [DW-1:0]    data_o,
    output logic [63:0]      pc_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             hang
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [15:0]      STK_MAX = '1;
    localparam logic [16:0]      LIMIT   = 17'(HANG_LIMIT);

    logic        stream, flush, keep;
    logic [15:0] streak;
    logic [16:0] streak_nxt;

    assign stream     = (wr_ctrl == 2'b00);
    assign flush      = (wr_ctrl == 2'b01);
    assign keep       = wr_ctrl[1];
    assign streak_nxt = {1'b0, streak} + 17'd1;

    // Payload registers: keep holds, flush loads a bubble and drops any held entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            pc_o    <= '0;
        end else if (stream) begin
            valid_o <= valid_i;
            data_o  <= data_i;
            pc_o    <= pc_i;
        end else if (flush) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            pc_o    <= '0;
        end
    end

    // Perf state: perf_clr beats any increment in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || perf_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            streak    <= '0;
            hang      <= 1'b0;
        end else begin
            if (keep && valid_o && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + 1'b1;
            if (keep) begin
                if (streak != STK_MAX)
                    streak <= streak_nxt[15:0];
                if (streak_nxt == LIMIT)
                    hang <= 1'b1;
            end else begin
                streak <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a spec-level model pushes expected outputs to a
// scoreboard queue on each driven cycle; they are popped and compared after the edge.
module tb_pipe_stage_reg;

    localparam int DW = 64, CNT_W = 2, HL = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       wr_ctrl = 2'b00;
    logic             valid_i = 1'b0;
    logic [DW-1:0]    data_i = '0;
    logic [63:0]      pc_i = '0;
    logic             perf_clr = 1'b0;
    logic             valid_o;
    logic [DW-1:0]    data_o;
    logic [63:0]      pc_o;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             hang;

    pipe_stage_reg #(.DW(DW), .CNT_W(CNT_W), .HANG_LIMIT(HL)) dut (
        .clk(clk), .reset(reset), .wr_ctrl(wr_ctrl), .valid_i(valid_i),
        .data_i(data_i), .pc_i(pc_i), .perf_clr(perf_clr), .valid_o(valid_o),
        .data_o(data_o), .pc_o(pc_o), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .hang(hang)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic [63:0] pc;
        logic [1:0]  s;
        logic [1:0]  f;
        logic        h;
    } exp_t;

    exp_t sb[$];
    int checks = 0, errors = 0;

    // Reference state derived from the behaviour description.
    logic        m_v = 0, m_h = 0;
    logic [63:0] m_d = 0, m_pc = 0;
    int          m_s = 0, m_f = 0, m_streak = 0;

    always @(posedge clk)
        if (!reset)
            assert (!$isunknown(wr_ctrl)) else begin
                errors++;
                $error("FAIL wr_ctrl_x obs=%b exp=known", wr_ctrl);
            end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic [1:0] c, input logic v,
                       input logic [63:0] d, input logic [63:0] p, input logic clr);
        exp_t e, got;
        @(negedge clk);
        reset = r; wr_ctrl = c; valid_i = v; data_i = d; pc_i = p; perf_clr = clr;
        if (r || clr) begin
            m_s = 0; m_f = 0; m_streak = 0; m_h = 0;
        end else begin
            if (c[1] && m_v && m_s < 3) m_s++;
            if (c == 2'b01 && m_f < 3) m_f++;
            if (c[1]) begin
                if (m_streak + 1 == HL) m_h = 1;
                if (m_streak < 65535) m_streak++;
            end else m_streak = 0;
        end
        if (r || c == 2'b01) begin
            m_v = 0; m_d = 0; m_pc = 0;
        end else if (c == 2'b00) begin
            m_v = v; m_d = d; m_pc = p;
        end
        e.v = m_v; e.d = m_d; e.pc = m_pc; e.s = 2'(m_s); e.f = 2'(m_f); e.h = m_h;
        sb.push_back(e);
        @(posedge clk); #1;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL sb_empty obs=0 exp=1");
        end
        if (sb.size() != 0) begin
            got = sb.pop_front();
            chk("valid_o",   64'(valid_o),   64'(got.v));
            chk("data_o",    data_o,         got.d);
            chk("pc_o",      pc_o,           got.pc);
            chk("stall_cnt", 64'(stall_cnt), 64'(got.s));
            chk("flush_cnt", 64'(flush_cnt), 64'(got.f));
            chk("hang",      64'(hang),      64'(got.h));
        end
    endtask

    initial begin
        // reset state
        cyc(1, 2'b00, 1, 64'hFF, 64'hFF, 0);
        cyc(1, 2'b00, 1, 64'hFF, 64'hFF, 0);
        chk("rst_valid", 64'(valid_o), 64'd0);
        // T1 stream
        cyc(0, 2'b00, 1, 64'hA5, 64'h8000_0000, 0);
        chk("t1_data", data_o, 64'hA5);
        chk("t1_pc", pc_o, 64'h8000_0000);
        // T2 stall then resume
        cyc(0, 2'b00, 1, 64'h11, 64'h100, 0);
        cyc(0, 2'b11, 1, 64'h22, 64'h200, 0);
        cyc(0, 2'b10, 1, 64'h22, 64'h200, 0);
        cyc(0, 2'b11, 1, 64'h22, 64'h200, 0);
        chk("t2_hold", data_o, 64'h11);
        chk("t2_stall", 64'(stall_cnt), 64'd3);
        cyc(0, 2'b00, 1, 64'h22, 64'h200, 0);
        chk("t2_resume", data_o, 64'h22);
        // streak cleared by 00: 3 more keeps must not raise hang
        cyc(0, 2'b11, 1, 64'h0, 64'h0, 0);
        cyc(0, 2'b11, 1, 64'h0, 64'h0, 0);
        cyc(0, 2'b11, 1, 64'h0, 64'h0, 0);
        chk("t4_no_hang3", 64'(hang), 64'd0);
        cyc(0, 2'b10, 1, 64'h0, 64'h0, 0);
        chk("t4_hang4", 64'(hang), 64'd1);
        // T3 flush
        cyc(0, 2'b00, 1, 64'h33, 64'h300, 1);
        cyc(0, 2'b01, 1, 64'h44, 64'h400, 0);
        chk("t3_flush_v", 64'(valid_o), 64'd0);
        chk("t3_flush_cnt1", 64'(flush_cnt), 64'd1);
        cyc(0, 2'b01, 1, 64'h44, 64'h400, 0);
        chk("t3_flush_cnt2", 64'(flush_cnt), 64'd2);
        chk("t3_stall_same", 64'(stall_cnt), 64'd0);
        cyc(0, 2'b11, 1, 64'h44, 64'h400, 0);   // keep with valid_o=0: no stall count
        cyc(0, 2'b01, 0, 64'h0, 64'h0, 0);
        cyc(0, 2'b01, 0, 64'h0, 64'h0, 0);      // flush_cnt saturates at 3
        chk("flush_sat", 64'(flush_cnt), 64'd3);
        // flush after keep drops the held entry
        cyc(0, 2'b00, 1, 64'h44, 64'h440, 1);
        cyc(0, 2'b10, 1, 64'h45, 64'h450, 0);
        cyc(0, 2'b01, 1, 64'h46, 64'h460, 0);
        cyc(0, 2'b00, 0, 64'h47, 64'h470, 0);
        chk("flush_drop", data_o, 64'h47);
        // T5 saturate and clear
        cyc(0, 2'b00, 1, 64'h55, 64'h500, 1);
        repeat (5) cyc(0, 2'b11, 1, 64'h99, 64'h900, 0);
        chk("t5_sat", 64'(stall_cnt), 64'd3);
        cyc(0, 2'b10, 1, 64'h99, 64'h900, 1);
        chk("t5_clr", 64'(stall_cnt), 64'd0);
        chk("t5_hold", data_o, 64'h55);
        chk("t5_hang_clr", 64'(hang), 64'd0);
        // perf_clr does not touch payload while streaming
        cyc(0, 2'b00, 1, 64'h66, 64'h600, 1);
        chk("clr_stream", data_o, 64'h66);
        // T6 reset mid-stall
        repeat (4) cyc(0, 2'b11, 1, 64'h77, 64'h700, 0);
        chk("t6_pre_hang", 64'(hang), 64'd1);
        cyc(1, 2'b11, 1, 64'h77, 64'h700, 0);
        chk("t6_data", data_o, 64'd0);
        chk("t6_hang", 64'(hang), 64'd0);
        chk("t6_stall", 64'(stall_cnt), 64'd0);
        cyc(0, 2'b11, 1, 64'h88, 64'h800, 0);
        chk("t6_no_replay", 64'(valid_o), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
